sync_fifo_ram: RTL and testbench
================================

// Module: sync_fifo_ram
// PURPOSE
//  Single-clock parametrised FIFO. Storage is an internal dual-port array: one
//  write port and one registered read port. Adds pointer management, flags,
//  occupancy count, sticky error flags and an optional first-word-fall-through
//  (FWFT) read mode. Used as the same-domain buffer between pipeline stages.
// PARAMETERS
//  ADDR_WIDTH  6              address bits; DEPTH = 2**ADDR_WIDTH
//  DATA_WIDTH  8              word width
//  DEPTH       2**ADDR_WIDTH  derived; do not override
//  FWFT        0              0 = standard read (1-cycle latency); 1 = FWFT
//  AFULL_TH    DEPTH-4        almost_full when count >= AFULL_TH
//  AEMPTY_TH   4              almost_empty when count <= AEMPTY_TH
// PORTS
//  clk           in   1             single clock, rising edge
//  reset_n       in   1             asynchronous reset, active low
//  wen           in   1             write request
//  wdata         in   DATA_WIDTH    write data
//  ren           in   1             read request (FWFT: pop/acknowledge)
//  rdata         out  DATA_WIDTH    read data, registered
//  rvalid        out  1             rdata holds a valid word (see BEHAVIOUR)
//  full          out  1             no free entry
//  empty         out  1             no readable entry
//  almost_full   out  1             count >= AFULL_TH
//  almost_empty  out  1             count <= AEMPTY_TH
//  count         out  ADDR_WIDTH+1  stored words, 0..DEPTH
//  overflow      out  1             sticky: write attempted while full
//  underflow     out  1             sticky: read attempted while empty
// BEHAVIOUR
//  - Reset (reset_n=0, async): wptr=rptr=0, count=0, rdata=0, rvalid=0,
//    empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0.
//    Array contents not reset. Reset mid-operation discards all stored words.
//  - Pointers: binary, ADDR_WIDTH+1 bits; low bits address the array, MSB is
//    the wrap bit. Wrap from DEPTH-1 to 0 is natural modulo rollover.
//  - full = (wptr[MSB] != rptr[MSB]) && (low bits equal); uses registered state.
//  - Write accepted iff wen && !full: array[wptr] <= wdata, wptr++ at the edge.
//    wen && full: write dropped, overflow <= 1 at that edge.
//  - FWFT=0: empty = (wptr == rptr). Read accepted iff ren && !empty:
//    rdata <= array[rptr], rptr++; rvalid = 1 for exactly the next cycle.
//    Otherwise rvalid=0 and rdata holds. ren && empty: underflow <= 1.
//  - FWFT=1: one-entry output register; empty = !rvalid. When the register is
//    empty or popped (ren && rvalid) and the array holds words, prefetch
//    array[rptr] into rdata, rptr++, rvalid=1. A word written into an empty
//    FIFO at edge N shows rvalid=1 after edge N+1. ren && !rvalid: underflow<=1.
//  - Flags are evaluated on pre-edge state; no write-through:
//    full with wen&&ren: read accepted, write dropped (overflow set).
//    empty with wen&&ren: write accepted, read refused (underflow set).
//  - count: +1 on accepted write, -1 on accepted read/pop, unchanged when both
//    occur. count includes the FWFT output-register word. Never exceeds DEPTH.
//  - almost_full/almost_empty: combinational from the count register.
//  - overflow/underflow cleared only by reset.
// TESTING
//  1 Reset: reset_n=0 mid-stream -> all outputs at reset values immediately;
//    after release, empty=1, count=0.
//  2 FWFT=0, write 0x11,0x22,0x33, then ren x3 -> rdata 0x11,0x22,0x33 with
//    rvalid one cycle after each ren; empty=1, count=0 at the end.
//  3 Fill 64 words (defaults) -> full=1, count=64, almost_full from count=60;
//    65th write dropped, overflow=1; drain returns words 0..63 in order.
//  4 count=64, wen&&ren together -> read ok, write dropped, count=63,
//    overflow=1; count=0, wen&&ren -> write ok, underflow=1, count=1.
//  5 Wrap: 200 interleaved writes/reads at count~10 -> data order preserved,
//    flags correct across pointer rollover.
//  6 FWFT=1, write 0xA5 at edge N -> rvalid=1, rdata=0xA5 after edge N+1;
//    ren pops it; rvalid=0 next cycle; ren while rvalid=0 -> underflow=1.

Source files
------------

// File: rtl/sync_fifo_ram_if.sv
// Bus bundle for sync_fifo_ram. The producer/consumer side uses the master modport.
// The FIFO side uses the slave modport.
interface sync_fifo_ram_if #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8
);
  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wen, wdata, ren,
    input  rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wen, wdata, ren,
    output rdata, rvalid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_ram.sv
// Single-clock FIFO over an internal dual-port array with a registered read port.
// Supports a standard read mode (1-cycle latency) or first-word-fall-through, plus flags and sticky errors.
module sync_fifo_ram #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 2 ** ADDR_WIDTH,
  parameter int FWFT       = 0,
  parameter int AFULL_TH   = DEPTH - 4,
  parameter int AEMPTY_TH  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  sync_fifo_ram_if.slave  bus
);

  localparam logic [ADDR_WIDTH:0] C_DEPTH   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AFULL   = (ADDR_WIDTH+1)'(AFULL_TH);
  localparam logic [ADDR_WIDTH:0] C_AEMPTY  = (ADDR_WIDTH+1)'(AEMPTY_TH);
  localparam logic [ADDR_WIDTH:0] C_ONE     = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic [ADDR_WIDTH:0]   r_wptr;
  logic [ADDR_WIDTH:0]   r_rptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rvalid;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_ptr_full;
  logic                  w_arr_empty;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_acc;
  logic                  w_pop;
  logic                  w_arr_rd;
  logic [ADDR_WIDTH:0]   w_wptr_nxt;
  logic [ADDR_WIDTH:0]   w_rptr_nxt;
  logic [ADDR_WIDTH:0]   w_count_nxt;
  logic [DATA_WIDTH-1:0] w_rdata_nxt;
  logic                  w_rvalid_nxt;
  logic                  w_overflow_nxt;
  logic                  w_underflow_nxt;

  // Flag decode from registered pointers, count and output-register state.
  always_comb begin
    w_ptr_full  = (r_wptr[ADDR_WIDTH] != r_rptr[ADDR_WIDTH]) &&
                  (r_wptr[ADDR_WIDTH-1:0] == r_rptr[ADDR_WIDTH-1:0]);
    w_arr_empty = (r_wptr == r_rptr);
    // In FWFT mode the output register adds one slot, so count also caps fullness at DEPTH.
    w_full      = w_ptr_full || (r_count == C_DEPTH);
    if (FWFT != 0) begin
      w_empty = !r_rvalid;
    end else begin
      w_empty = w_arr_empty;
    end
  end

  // Accept decisions and next-state values, all on pre-edge state.
  always_comb begin
    w_wr_acc        = 1'b0;
    w_pop           = 1'b0;
    w_arr_rd        = 1'b0;
    w_rvalid_nxt    = 1'b0;
    w_rdata_nxt     = r_rdata;
    w_wptr_nxt      = r_wptr;
    w_rptr_nxt      = r_rptr;
    w_count_nxt     = r_count;
    w_overflow_nxt  = r_overflow || (bus.wen && w_full);
    w_underflow_nxt = r_underflow || (bus.ren && w_empty);

    w_wr_acc = bus.wen && !w_full;
    if (FWFT != 0) begin
      w_pop        = bus.ren && r_rvalid;
      w_arr_rd     = (!r_rvalid || w_pop) && !w_arr_empty;
      if (w_arr_rd) begin
        w_rvalid_nxt = 1'b1;
      end else if (w_pop) begin
        w_rvalid_nxt = 1'b0;
      end else begin
        w_rvalid_nxt = r_rvalid;
      end
    end else begin
      w_pop        = bus.ren && !w_arr_empty;
      w_arr_rd     = w_pop;
      w_rvalid_nxt = w_pop;
    end

    if (w_arr_rd) begin
      w_rdata_nxt = r_mem[r_rptr[ADDR_WIDTH-1:0]];
      w_rptr_nxt  = r_rptr + C_ONE;
    end else begin
      w_rdata_nxt = r_rdata;
      w_rptr_nxt  = r_rptr;
    end

    if (w_wr_acc) begin
      w_wptr_nxt = r_wptr + C_ONE;
    end else begin
      w_wptr_nxt = r_wptr;
    end

    case ({w_wr_acc, w_pop})
      2'b10:   w_count_nxt = r_count + C_ONE;
      2'b01:   w_count_nxt = r_count - C_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // Storage array write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wptr[ADDR_WIDTH-1:0]] <= bus.wdata;
    end
  end

  // Control and output state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_rdata     <= '0;
      r_rvalid    <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wptr      <= w_wptr_nxt;
      r_rptr      <= w_rptr_nxt;
      r_count     <= w_count_nxt;
      r_rdata     <= w_rdata_nxt;
      r_rvalid    <= w_rvalid_nxt;
      r_overflow  <= w_overflow_nxt;
      r_underflow <= w_underflow_nxt;
    end
  end

  assign bus.rdata        = r_rdata;
  assign bus.rvalid       = r_rvalid;
  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.count        = r_count;
  assign bus.almost_full  = (r_count >= C_AFULL);
  assign bus.almost_empty = (r_count <= C_AEMPTY);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_ram.sv
// Directed bench for sync_fifo_ram: one instance in standard read mode and one in FWFT mode.
// Inputs change on the falling edge, and outputs are sampled on the falling edge.
module tb_sync_fifo_ram;
  localparam int AW = 6;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sync_fifo_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  sync_fifo_ram_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  sync_fifo_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .bus(bus0));
  sync_fifo_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .bus(bus1));

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Standard-mode flags for a given expected count.
  task automatic flags0(input string tag, input int c);
    chk({tag, ".count"}, 32'(bus0.count), 32'(c));
    chk({tag, ".empty"}, 32'(bus0.empty), 32'(c == 0));
    chk({tag, ".full"},  32'(bus0.full),  32'(c == 64));
    chk({tag, ".afull"}, 32'(bus0.almost_full),  32'(c >= 60));
    chk({tag, ".aempt"}, 32'(bus0.almost_empty), 32'(c <= 4));
  endtask

  task automatic cyc0(input logic w, input logic [7:0] d, input logic r);
    bus0.wen = w; bus0.wdata = d; bus0.ren = r;
    @(negedge clk);
    bus0.wen = 1'b0; bus0.ren = 1'b0;
  endtask

  task automatic cyc1(input logic w, input logic [7:0] d, input logic r);
    bus1.wen = w; bus1.wdata = d; bus1.ren = r;
    @(negedge clk);
    bus1.wen = 1'b0; bus1.ren = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic       wr_ok, rd_ok, w, r;
  logic [7:0] d;

  initial begin
    reset_n = 1'b0;
    bus0.wen = 1'b0; bus0.wdata = 8'h00; bus0.ren = 1'b0;
    bus1.wen = 1'b0; bus1.wdata = 8'h00; bus1.ren = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.rdata", 32'(bus0.rdata), 32'h0);
    chk("rst.rvalid", 32'(bus0.rvalid), 32'h0);
    chk("rst.ovf", 32'(bus0.overflow), 32'h0);
    chk("rst.unf", 32'(bus0.underflow), 32'h0);
    flags0("rst", 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Mid-stream reset: one word still stored, rvalid high, rdata non-zero.
    cyc0(1'b1, 8'h5A, 1'b0);
    cyc0(1'b1, 8'hC3, 1'b0);
    cyc0(1'b0, 8'h00, 1'b1);
    chk("pre.rdata", 32'(bus0.rdata), 32'h5A);
    chk("pre.rvalid", 32'(bus0.rvalid), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst.rdata", 32'(bus0.rdata), 32'h0);
    chk("arst.rvalid", 32'(bus0.rvalid), 32'h0);
    flags0("arst", 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    flags0("rel", 0);

    // Standard-mode basic write then read.
    cyc0(1'b1, 8'h11, 1'b0);
    cyc0(1'b1, 8'h22, 1'b0);
    cyc0(1'b1, 8'h33, 1'b0);
    flags0("w3", 3);
    cyc0(1'b0, 8'h00, 1'b1);
    chk("r1.rdata", 32'(bus0.rdata), 32'h11);
    chk("r1.rvalid", 32'(bus0.rvalid), 32'h1);
    cyc0(1'b0, 8'h00, 1'b1);
    chk("r2.rdata", 32'(bus0.rdata), 32'h22);
    chk("r2.rvalid", 32'(bus0.rvalid), 32'h1);
    cyc0(1'b0, 8'h00, 1'b1);
    chk("r3.rdata", 32'(bus0.rdata), 32'h33);
    chk("r3.rvalid", 32'(bus0.rvalid), 32'h1);
    cyc0(1'b0, 8'h00, 1'b0);
    chk("idle.rvalid", 32'(bus0.rvalid), 32'h0);
    chk("idle.rdata", 32'(bus0.rdata), 32'h33);
    flags0("idle", 0);

    // Fill to full and check thresholds at every count.
    for (int i = 0; i < 64; i++) begin
      cyc0(1'b1, 8'(i), 1'b0);
      flags0($sformatf("fill%0d", i), i + 1);
    end
    cyc0(1'b1, 8'hEE, 1'b0);
    flags0("ovf", 64);
    chk("ovf.flag", 32'(bus0.overflow), 32'h1);

    // Simultaneous write and read while full: the read is accepted and the write is dropped.
    cyc0(1'b1, 8'hDD, 1'b1);
    chk("fwr.rdata", 32'(bus0.rdata), 32'h00);
    chk("fwr.rvalid", 32'(bus0.rvalid), 32'h1);
    chk("fwr.ovf", 32'(bus0.overflow), 32'h1);
    flags0("fwr", 63);
    for (int i = 1; i < 64; i++) begin
      cyc0(1'b0, 8'h00, 1'b1);
      chk($sformatf("drain%0d", i), 32'(bus0.rdata), 32'(i));
    end
    flags0("drained", 0);
    chk("pre.unf", 32'(bus0.underflow), 32'h0);

    // Simultaneous write and read while empty: the write is accepted and the read is refused.
    cyc0(1'b1, 8'h77, 1'b1);
    chk("ewr.rvalid", 32'(bus0.rvalid), 32'h0);
    chk("ewr.rdata", 32'(bus0.rdata), 32'h3F);
    chk("ewr.unf", 32'(bus0.underflow), 32'h1);
    flags0("ewr", 1);
    cyc0(1'b0, 8'h00, 1'b1);
    chk("ewr.rd", 32'(bus0.rdata), 32'h77);
    flags0("ewr.rd", 0);

    // Pointer wrap with interleaved traffic around count 10.
    for (int i = 0; i < 10; i++) begin
      cyc0(1'b1, 8'(8'h80 + i), 1'b0);
      q.push_back(8'(8'h80 + i));
    end
    for (int i = 0; i < 200; i++) begin
      w = (i % 4) != 2;
      r = (i % 4) != 0;
      d = 8'(i * 7 + 3);
      wr_ok = w && (q.size() < 64);
      rd_ok = r && (q.size() > 0);
      exp_d = 8'h00;
      if (rd_ok) exp_d = q.pop_front();
      if (wr_ok) q.push_back(d);
      cyc0(w, d, r);
      chk($sformatf("wrap%0d.rvalid", i), 32'(bus0.rvalid), 32'(rd_ok));
      if (rd_ok) chk($sformatf("wrap%0d.rdata", i), 32'(bus0.rdata), 32'(exp_d));
      flags0($sformatf("wrap%0d", i), q.size());
    end
    while (q.size() > 0) begin
      exp_d = q.pop_front();
      cyc0(1'b0, 8'h00, 1'b1);
      chk("wdrain", 32'(bus0.rdata), 32'(exp_d));
    end
    flags0("wend", 0);

    // FWFT instance: one-cycle prefetch after a write into an empty FIFO.
    chk("f.empty0", 32'(bus1.empty), 32'h1);
    chk("f.rvalid0", 32'(bus1.rvalid), 32'h0);
    cyc1(1'b1, 8'hA5, 1'b0);
    chk("f.N.rvalid", 32'(bus1.rvalid), 32'h0);
    chk("f.N.count", 32'(bus1.count), 32'h1);
    cyc1(1'b0, 8'h00, 1'b0);
    chk("f.N1.rvalid", 32'(bus1.rvalid), 32'h1);
    chk("f.N1.rdata", 32'(bus1.rdata), 32'hA5);
    chk("f.N1.empty", 32'(bus1.empty), 32'h0);
    cyc1(1'b0, 8'h00, 1'b1);
    chk("f.pop.rvalid", 32'(bus1.rvalid), 32'h0);
    chk("f.pop.count", 32'(bus1.count), 32'h0);
    chk("f.pop.unf", 32'(bus1.underflow), 32'h0);
    cyc1(1'b0, 8'h00, 1'b1);
    chk("f.unf", 32'(bus1.underflow), 32'h1);
    cyc1(1'b1, 8'h01, 1'b0);
    cyc1(1'b1, 8'h02, 1'b0);
    chk("f.b2b.rdata", 32'(bus1.rdata), 32'h01);
    chk("f.b2b.count", 32'(bus1.count), 32'h2);
    cyc1(1'b0, 8'h00, 1'b1);
    chk("f.pf.rvalid", 32'(bus1.rvalid), 32'h1);
    chk("f.pf.rdata", 32'(bus1.rdata), 32'h02);
    chk("f.pf.count", 32'(bus1.count), 32'h1);
    cyc1(1'b0, 8'h00, 1'b1);
    chk("f.end.rvalid", 32'(bus1.rvalid), 32'h0);
    chk("f.end.empty", 32'(bus1.empty), 32'h1);
    chk("f.end.ovf", 32'(bus1.overflow), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
